piso_serializer: RTL

- Parallel-in, serial-out transmitter for the team's serial-in shift-register receivers.
- Accepts a WIDTH-bit word through a valid/ready handshake and shifts it out MSB-first on dout, one bit per clk.
- Drives dout_en as the receiver's shift-enable. After WIDTH enabled cycles, a left-shifting receiver (new bit enters at LSB) holds the original word.
- An optional idle gap separates frames.

---
 rtl/piso_pkg.sv | 20 ++
 rtl/piso_serializer.sv | 85 ++++++++
 2 files changed

// File: rtl/piso_pkg.sv
// Shared definitions for the parallel-in serial-out transmitter.
// FSM state encodings and a counter-width helper.
package piso_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_SHIFT = ST_SHIFT,
        S_GAP   = ST_GAP
    } state_t;

    // Width needed to count 0..v-1, never narrower than one bit.
    function automatic int clog2_min1(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/piso_serializer.sv
// Purpose: WIDTH-bit word in via valid/ready, shifted out MSB-first on dout with dout_en strobe.
// Latency: first bit one cycle after the handshake; done one cycle after the last bit.
// Backpressure: din_ready is high only in IDLE; din_valid at any other time is ignored.
module piso_serializer
    import piso_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int GAP   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             dout,
    output logic             dout_en,
    output logic             busy,
    output logic             done
);

    localparam int CW = clog2_min1(WIDTH);
    localparam int GW = clog2_min1(GAP + 1);
    localparam logic [CW-1:0] BIT_LAST = CW'(WIDTH - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    bcnt;
    logic [GW-1:0]    gcnt;
    logic             done_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            shreg  <= '0;
            bcnt   <= '0;
            gcnt   <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (din_valid) begin
                        shreg <= din;
                        bcnt  <= '0;
                        state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    shreg <= {shreg[WIDTH-2:0], 1'b0};
                    if (bcnt == BIT_LAST) begin
                        // Counter wraps to 0 so it never holds a value above WIDTH-1.
                        bcnt   <= '0;
                        done_q <= 1'b1;
                        if (GAP > 0) begin
                            gcnt  <= '0;
                            state <= S_GAP;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        bcnt <= bcnt + CW'(1);
                    end
                end
                S_GAP: begin
                    if (gcnt == GAP_LAST) begin
                        gcnt  <= '0;
                        state <= S_IDLE;
                    end else begin
                        gcnt <= gcnt + GW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // All outputs come from registered state only; nothing combinational from din/din_valid.
    assign dout_en   = (state == S_SHIFT);
    assign dout      = dout_en & shreg[WIDTH-1];
    assign busy      = (state == S_SHIFT) || (state == S_GAP);
    assign din_ready = (state == S_IDLE);
    assign done      = done_q;

endmodule
